// File: rtl/rob_dispatch_alloc.sv
// rob_dispatch_alloc
//   Dispatch-side allocator for the reorder buffer. Owns the ROB tail (dispatch)
//   pointer, a shadow copy of the head (commit) pointer and the occupancy count.
//   Grants up to two entries per cycle, all-or-nothing, with zero latency.
//   Frees one entry per cycle on the commit pulse.
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   req1_i, req2_i   dispatch slot requests (req2_i only counts with req1_i)
//   commit_i         ROB retired its head entry this cycle
//   flush_i          discard all uncommitted entries (highest priority)
//   alloc_ready_o    every requested entry can be granted this cycle
//   dp1_o/dp2_o      per-slot grant / ROB write strobe
//   dp1_addr_o       tail
//   dp2_addr_o       tail+1 (mod ROB_NUM)
//   dispatch_ptr_o   tail pointer
//   head_ptr_o       allocator copy of the commit pointer
//   free_cnt_o       free entries, 0..ROB_NUM
//   full_o, empty_o  decodes of the registered count
//   underflow_o      sticky flag: commit seen while empty
module rob_dispatch_alloc #(
    parameter int ROB_NUM = 64,
    parameter int ROB_SEL = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req1_i,
    input  logic               req2_i,
    input  logic               commit_i,
    input  logic               flush_i,
    output logic               alloc_ready_o,
    output logic               dp1_o,
    output logic [ROB_SEL-1:0] dp1_addr_o,
    output logic               dp2_o,
    output logic [ROB_SEL-1:0] dp2_addr_o,
    output logic [ROB_SEL-1:0] dispatch_ptr_o,
    output logic [ROB_SEL-1:0] head_ptr_o,
    output logic [ROB_SEL:0]   free_cnt_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               underflow_o
);

    logic [ROB_SEL-1:0] tail_q, tail_d;
    logic [ROB_SEL-1:0] head_q, head_d;
    logic [ROB_SEL:0]   count_q, count_d;
    logic               underflow_q, underflow_d;

    logic [1:0]         need;
    logic [ROB_SEL:0]   free_cnt;
    logic               valid_commit;
    logic [ROB_SEL:0]   granted;

    assign free_cnt     = (ROB_SEL+1)'(ROB_NUM) - count_q;
    assign need         = {1'b0, req1_i} + {1'b0, req1_i & req2_i};
    assign valid_commit = commit_i & (count_q != '0);

    // Room is judged on the registered count only; a same-cycle commit does
    // not make room, which keeps commit off the grant timing path.
    assign alloc_ready_o = ~reset & ~flush_i & (free_cnt >= (ROB_SEL+1)'(need));
    assign dp1_o         = req1_i & alloc_ready_o;
    assign dp2_o         = dp1_o & req2_i;
    assign dp1_addr_o    = tail_q;
    assign dp2_addr_o    = tail_q + ROB_SEL'(1);
    assign granted       = (ROB_SEL+1)'(dp1_o) + (ROB_SEL+1)'(dp2_o);

    always_comb begin
        head_d      = head_q + ROB_SEL'(valid_commit);
        tail_d      = tail_q + ROB_SEL'(dp1_o) + ROB_SEL'(dp2_o);
        count_d     = count_q + granted - (ROB_SEL+1)'(valid_commit);
        underflow_d = underflow_q | (commit_i & (count_q == '0));
        if (flush_i) begin
            // Tail snaps to the post-commit head so a retiring entry is not lost.
            tail_d  = head_d;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tail_q      <= '0;
            head_q      <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            tail_q      <= tail_d;
            head_q      <= head_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    assign dispatch_ptr_o = tail_q;
    assign head_ptr_o     = head_q;
    assign free_cnt_o     = free_cnt;
    assign full_o         = (count_q == (ROB_SEL+1)'(ROB_NUM));
    assign empty_o        = (count_q == '0);
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_rob_dispatch_alloc.sv
module tb_rob_dispatch_alloc;

    logic       clk = 1'b0;
    logic       reset;
    logic       req1_i, req2_i, commit_i, flush_i;
    logic       alloc_ready_o, dp1_o, dp2_o, full_o, empty_o, underflow_o;
    logic [5:0] dp1_addr_o, dp2_addr_o, dispatch_ptr_o, head_ptr_o;
    logic [6:0] free_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rob_dispatch_alloc #(.ROB_NUM(64), .ROB_SEL(6)) dut (
        .clk(clk), .reset(reset),
        .req1_i(req1_i), .req2_i(req2_i), .commit_i(commit_i), .flush_i(flush_i),
        .alloc_ready_o(alloc_ready_o), .dp1_o(dp1_o), .dp1_addr_o(dp1_addr_o),
        .dp2_o(dp2_o), .dp2_addr_o(dp2_addr_o), .dispatch_ptr_o(dispatch_ptr_o),
        .head_ptr_o(head_ptr_o), .free_cnt_o(free_cnt_o), .full_o(full_o),
        .empty_o(empty_o), .underflow_o(underflow_o)
    );

    typedef struct {
        logic r1, r2, cm, fl;
        logic rdy, d1, d2;
        int   a1, a2, tail, head, free;
        logic full, empty, unf;
    } vec_t;

    vec_t tbl[12];
    vec_t sb_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r1, input logic r2, input logic cm, input logic fl);
        req1_i = r1; req2_i = r2; commit_i = cm; flush_i = fl;
    endtask

    task automatic edge1;
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        drive(1, 1, 0, 0);
        #2;
        chk("rst_ready", alloc_ready_o, 0);
        chk("rst_dp1", dp1_o, 0);
        chk("rst_dp2", dp2_o, 0);
        edge1();
        reset = 1'b0;
        drive(0, 0, 0, 0);
    endtask

    // From reset: 31 pairs plus one single -> tail 63, count 63.
    task automatic fill63;
        for (int i = 0; i < 31; i++) begin drive(1, 1, 0, 0); edge1(); end
        drive(1, 0, 0, 0); edge1();
        drive(0, 0, 0, 0);
    endtask

    initial begin
        // r1 r2 cm fl | rdy d1 d2 a1 a2 | tail head free full empty unf  (state before edge)
        tbl[0]  = '{1,1,0,0, 1,1,1,  0, 1,  0,0,64, 0,1,0};
        tbl[1]  = '{1,1,0,0, 1,1,1,  2, 3,  2,0,62, 0,0,0};
        tbl[2]  = '{1,1,0,0, 1,1,1,  4, 5,  4,0,60, 0,0,0};
        tbl[3]  = '{0,0,0,0, 1,0,0,  6, 7,  6,0,58, 0,0,0};
        tbl[4]  = '{0,1,0,0, 1,0,0,  6, 7,  6,0,58, 0,0,0};
        tbl[5]  = '{1,0,1,0, 1,1,0,  6, 7,  6,0,58, 0,0,0};
        tbl[6]  = '{1,1,1,0, 1,1,1,  7, 8,  7,1,58, 0,0,0};
        tbl[7]  = '{0,0,0,0, 1,0,0,  9,10,  9,2,57, 0,0,0};
        tbl[8]  = '{1,0,1,1, 0,0,0,  9,10,  9,2,57, 0,0,0};
        tbl[9]  = '{0,0,0,0, 1,0,0,  3, 4,  3,3,64, 0,1,0};
        tbl[10] = '{0,0,1,0, 1,0,0,  3, 4,  3,3,64, 0,1,0};
        tbl[11] = '{0,0,0,0, 1,0,0,  3, 4,  3,3,64, 0,1,1};

        do_reset();
        chk("post_rst_tail", dispatch_ptr_o, 0);
        chk("post_rst_free", free_cnt_o, 64);
        chk("post_rst_empty", empty_o, 1);
        chk("post_rst_full", full_o, 0);
        chk("post_rst_unf", underflow_o, 0);

        for (int i = 0; i < 12; i++) begin
            vec_t e;
            drive(tbl[i].r1, tbl[i].r2, tbl[i].cm, tbl[i].fl);
            sb_q.push_back(tbl[i]);
            #2;
            e = sb_q.pop_front();
            chk($sformatf("v%0d_rdy", i),   alloc_ready_o, e.rdy);
            chk($sformatf("v%0d_dp1", i),   dp1_o, e.d1);
            chk($sformatf("v%0d_dp2", i),   dp2_o, e.d2);
            chk($sformatf("v%0d_a1", i),    dp1_addr_o, e.a1);
            chk($sformatf("v%0d_a2", i),    dp2_addr_o, e.a2);
            chk($sformatf("v%0d_tail", i),  dispatch_ptr_o, e.tail);
            chk($sformatf("v%0d_head", i),  head_ptr_o, e.head);
            chk($sformatf("v%0d_free", i),  free_cnt_o, e.free);
            chk($sformatf("v%0d_full", i),  full_o, e.full);
            chk($sformatf("v%0d_empty", i), empty_o, e.empty);
            chk($sformatf("v%0d_unf", i),   underflow_o, e.unf);
            edge1();
        end
        chk("unf_sticky", underflow_o, 1);

        // Fill to one free entry, then exercise the full boundary.
        do_reset();
        chk("unf_cleared", underflow_o, 0);
        fill63();
        chk("fill_free", free_cnt_o, 1);
        chk("fill_tail", dispatch_ptr_o, 63);
        drive(1, 1, 0, 0); #2;
        chk("need2_ready", alloc_ready_o, 0);
        chk("need2_dp1", dp1_o, 0);
        chk("need2_dp2", dp2_o, 0);
        edge1();
        chk("need2_free", free_cnt_o, 1);
        chk("need2_tail", dispatch_ptr_o, 63);
        drive(1, 0, 0, 0); #2;
        chk("last_dp1", dp1_o, 1);
        chk("last_addr", dp1_addr_o, 63);
        chk("last_full_before", full_o, 0);
        edge1();
        chk("full_set", full_o, 1);
        chk("full_free", free_cnt_o, 0);
        chk("full_tail", dispatch_ptr_o, 0);
        drive(1, 0, 1, 0); #2;
        chk("full_commit_ready", alloc_ready_o, 0);
        chk("full_commit_dp1", dp1_o, 0);
        edge1();
        drive(0, 0, 0, 0);
        chk("after_commit_free", free_cnt_o, 1);
        chk("after_commit_head", head_ptr_o, 1);
        chk("after_commit_full", full_o, 0);

        // Wrap: tail 63, head 62.
        do_reset();
        fill63();
        for (int i = 0; i < 62; i++) begin drive(0, 0, 1, 0); edge1(); end
        drive(0, 0, 0, 0);
        chk("wrap_head", head_ptr_o, 62);
        chk("wrap_free", free_cnt_o, 63);
        drive(1, 1, 0, 0); #2;
        chk("wrap_a1", dp1_addr_o, 63);
        chk("wrap_a2", dp2_addr_o, 0);
        chk("wrap_dp2", dp2_o, 1);
        edge1();
        drive(0, 0, 0, 0);
        chk("wrap_tail", dispatch_ptr_o, 1);
        chk("wrap_free2", free_cnt_o, 61);

        // Reset mid-operation discards state.
        do_reset();
        chk("midrst_tail", dispatch_ptr_o, 0);
        chk("midrst_head", head_ptr_o, 0);
        chk("midrst_empty", empty_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
